// File: rtl/bchan_pkg.sv
// Shared B-channel definitions: BRESP encodings and output-register state.
package bchan_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bstate_e;

endpackage

// File: rtl/bchan_rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr (cyclically) wins.
module bchan_rr_arbiter #(
    parameter int NUM_SLV = 5
) (
    input  logic [NUM_SLV-1:0]         req,
    input  logic [$clog2(NUM_SLV)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_SLV-1:0]         grant,
    output logic [$clog2(NUM_SLV)-1:0] grant_idx
);
    localparam int PW = $clog2(NUM_SLV);
    localparam logic [PW:0] NS = (PW+1)'(NUM_SLV);

    logic [PW:0] idx;
    logic        found;

    // Scan ptr, ptr+1, ... wrapping; one extra bit holds ptr+i before wrap.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            idx = {1'b0, ptr} + (PW+1)'(i);
            if (idx >= NS) idx = idx - NS;
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/bchan_rr_router.sv
// B-channel N:1 router with round-robin arbitration into a one-entry
// output register. Optional BCHAN_ERR_CNT_EN adds a saturating error counter.
module bchan_rr_router
    import bchan_pkg::*;
#(
    parameter int NUM_SLV    = 5,
    parameter int sID_width  = 6,
    parameter int mID_width  = 2,
    parameter int user_width = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SLV*sID_width-1:0]    s_BID,
    input  logic [NUM_SLV*2-1:0]            s_BRESP,
    input  logic [NUM_SLV*user_width-1:0]   s_BUSER,
    input  logic [NUM_SLV-1:0]              s_BVALID,
    output logic [NUM_SLV-1:0]              s_BREADY,
    output logic [mID_width-1:0]            m_BID,
    output logic [1:0]                      m_BRESP,
    output logic [user_width-1:0]           m_BUSER,
    output logic                            m_BVALID,
    input  logic                            m_BREADY,
    output logic [$clog2(NUM_SLV)-1:0]      B_src
`ifdef BCHAN_ERR_CNT_EN
    ,
    output logic [15:0]                     err_cnt
`endif
);
    localparam int PW = $clog2(NUM_SLV);
    localparam logic [PW-1:0] LAST = PW'(NUM_SLV - 1);

    bstate_e             state, state_nxt;
    logic [PW-1:0]       ptr;
    logic                load_en;
    logic                accept;
    logic [NUM_SLV-1:0]  grant;
    logic [PW-1:0]       grant_idx;
    logic                unused_bid;

    // Upper slave ID bits are intentionally dropped on the master side.
    assign unused_bid = ^s_BID;

    assign load_en  = (state == EMPTY) || (state == FULL && m_BVALID && m_BREADY);
    assign accept   = |grant;
    assign s_BREADY = grant;

    bchan_rr_arbiter #(.NUM_SLV(NUM_SLV)) u_arb (
        .req       (s_BVALID),
        .ptr       (ptr),
        .en        (load_en && !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Next state: a fresh accept always fills; a drained handshake empties.
    always_comb begin
        state_nxt = state;
        if (accept)                        state_nxt = FULL;
        else if (state == FULL && m_BREADY) state_nxt = EMPTY;
    end

    // Output decode.
    always_comb begin
        m_BVALID = (state == FULL);
    end

    // Payload capture and round-robin pointer advance on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr     <= '0;
            m_BID   <= '0;
            m_BRESP <= RESP_OKAY;
            m_BUSER <= '0;
            B_src   <= '0;
        end else if (accept) begin
            m_BID   <= s_BID[grant_idx*sID_width +: mID_width];
            m_BRESP <= s_BRESP[grant_idx*2 +: 2];
            m_BUSER <= s_BUSER[grant_idx*user_width +: user_width];
            B_src   <= grant_idx;
            ptr     <= (grant_idx == LAST) ? '0 : grant_idx + PW'(1);
        end
    end

`ifdef BCHAN_ERR_CNT_EN
    // Count SLVERR/DECERR responses delivered to the master, saturating.
    always_ff @(posedge clk) begin
        if (reset)
            err_cnt <= '0;
        else if (m_BVALID && m_BREADY &&
                 (m_BRESP == RESP_SLVERR || m_BRESP == RESP_DECERR) &&
                 err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bchan_rr_router.sv
// Self-checking bench for bchan_rr_router against a behavioural model.
module tb_bchan_rr_router;
    localparam int N  = 5;
    localparam int SW = 6;
    localparam int MW = 2;
    localparam int UW = 1;
    localparam int PW = $clog2(N);
    localparam int BW = N * SW;
    localparam int RW = N * 2;
    localparam int XW = N * UW;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] s_BID;
    logic [RW-1:0] s_BRESP;
    logic [XW-1:0] s_BUSER;
    logic [N-1:0]  s_BVALID;
    logic [N-1:0]  s_BREADY;
    logic [MW-1:0] m_BID;
    logic [1:0]    m_BRESP;
    logic [UW-1:0] m_BUSER;
    logic          m_BVALID;
    logic          m_BREADY;
    logic [PW-1:0] B_src;
`ifdef BCHAN_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    int            md_ptr;
    bit            md_full;
    logic [MW-1:0] e_bid;
    logic [1:0]    e_resp;
    logic [UW-1:0] e_user;
    int            e_src;
    logic [N-1:0]  e_ready;
    int            e_err;

    always #5 clk = ~clk;

    bchan_rr_router #(.NUM_SLV(N), .sID_width(SW), .mID_width(MW), .user_width(UW)) dut (
        .clk(clk), .reset(reset),
        .s_BID(s_BID), .s_BRESP(s_BRESP), .s_BUSER(s_BUSER),
        .s_BVALID(s_BVALID), .s_BREADY(s_BREADY),
        .m_BID(m_BID), .m_BRESP(m_BRESP), .m_BUSER(m_BUSER),
        .m_BVALID(m_BVALID), .m_BREADY(m_BREADY), .B_src(B_src)
`ifdef BCHAN_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    // Which slave the spec's rules pick this cycle, -1 for none.
    function automatic int pick();
        if (reset || (md_full && !m_BREADY)) return -1;
        for (int k = 0; k < N; k++)
            if (s_BVALID[(md_ptr + k) % N]) return (md_ptr + k) % N;
        return -1;
    endfunction

    task automatic settle();
        int g;
        #1;
        g = pick();
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        g = pick();
        if (reset) begin
            md_full = 0; md_ptr = 0; e_bid = '0; e_resp = '0; e_user = '0; e_src = 0; e_err = 0;
        end else begin
            if (md_full && m_BREADY && e_resp[1] && e_err < 65535) e_err++;
            if (g >= 0) begin
                e_bid   = s_BID[g*SW +: MW];
                e_resp  = s_BRESP[g*2 +: 2];
                e_user  = s_BUSER[g*UW +: UW];
                e_src   = g;
                md_ptr  = (g + 1) % N;
                md_full = 1;
            end else if (md_full && m_BREADY) begin
                md_full = 0;
            end
        end
        #1;
    endtask

    task automatic rand_payload();
        s_BID   = BW'($urandom);
        s_BRESP = RW'($urandom);
        s_BUSER = XW'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1; settle(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_BVALID = 5'b11111; m_BREADY = 1'b1; rand_payload();
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (s_BREADY !== 5'b00000) begin errors++; $display("FAIL reset_ready got=%b exp=00000", s_BREADY); end
            tick();
            checks++;
            if (m_BVALID !== 1'b0 || B_src !== 3'd0 || m_BID !== 2'd0 || m_BRESP !== 2'd0) begin
                errors++; $display("FAIL reset_out valid=%b src=%0d bid=%0d resp=%0d exp 0", m_BVALID, B_src, m_BID, m_BRESP);
            end
        end
        reset = 1'b0; s_BVALID = '0;
    endtask

    task automatic test_single();
        s_BVALID = 5'b00100; s_BID = '0; s_BID[2*SW +: SW] = 6'h2D;
        s_BRESP = '0; m_BREADY = 1'b1;
        settle();
        checks++;
        if (s_BREADY !== 5'b00100) begin errors++; $display("FAIL single_ready got=%b exp=00100", s_BREADY); end
        tick();
        s_BVALID = '0;
        checks++;
        if (m_BVALID !== 1'b1 || m_BID !== 2'b01 || B_src !== 3'd2 || m_BRESP !== 2'b00) begin
            errors++; $display("FAIL single_out valid=%b bid=%b src=%0d resp=%b exp 1/01/2/00", m_BVALID, m_BID, B_src, m_BRESP);
        end
        settle(); tick();
        checks++;
        if (m_BVALID !== 1'b0) begin errors++; $display("FAIL single_drain valid=%b exp=0", m_BVALID); end
    endtask

    task automatic test_fairness();
        int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
        do_reset();
        s_BVALID = 5'b11111; m_BREADY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            rand_payload();
            settle();
            checks++;
            if (s_BREADY !== 5'(1 << exp_seq[c])) begin
                errors++; $display("FAIL fair_ready c=%0d got=%b exp_idx=%0d", c, s_BREADY, exp_seq[c]);
            end
            tick();
            checks++;
            if (m_BVALID !== 1'b1 || int'(B_src) != exp_seq[c] || m_BID !== e_bid) begin
                errors++; $display("FAIL fair_out c=%0d src=%0d exp=%0d bid=%0d exp=%0d", c, B_src, exp_seq[c], m_BID, e_bid);
            end
        end
        s_BVALID = '0; settle(); tick();
    endtask

    task automatic test_backpressure();
        logic [MW-1:0] held_bid;
        do_reset();
        rand_payload(); s_BVALID = 5'b00001; m_BREADY = 1'b0;
        held_bid = s_BID[MW-1:0];
        settle(); tick();
        s_BVALID = 5'b01010;
        for (int c = 0; c < 4; c++) begin
            rand_payload();
            settle();
            checks++;
            if (s_BREADY !== 5'b00000) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=00000", c, s_BREADY); end
            tick();
            checks++;
            if (m_BVALID !== 1'b1 || B_src !== 3'd0 || m_BID !== held_bid) begin
                errors++; $display("FAIL bp_hold c=%0d valid=%b src=%0d bid=%0d exp 1/0/%0d", c, m_BVALID, B_src, m_BID, held_bid);
            end
        end
        m_BREADY = 1'b1;
        settle();
        checks++;
        if (s_BREADY !== 5'b00010) begin errors++; $display("FAIL bp_release got=%b exp=00010", s_BREADY); end
        tick();
        checks++;
        if (B_src !== 3'd1 || m_BVALID !== 1'b1) begin errors++; $display("FAIL bp_next src=%0d exp=1", B_src); end
        s_BVALID = '0; settle(); tick();
    endtask

    task automatic test_reset_mid();
        s_BVALID = 5'b10000; m_BREADY = 1'b0; rand_payload();
        settle(); tick();
        checks++;
        if (m_BVALID !== 1'b1 || B_src !== 3'd4) begin errors++; $display("FAIL rmid_load valid=%b src=%0d exp 1/4", m_BVALID, B_src); end
        reset = 1'b1;
        settle();
        checks++;
        if (s_BREADY !== 5'b00000) begin errors++; $display("FAIL rmid_ready got=%b exp=00000", s_BREADY); end
        tick();
        checks++;
        if (m_BVALID !== 1'b0 || B_src !== 3'd0) begin errors++; $display("FAIL rmid_clear valid=%b src=%0d exp 0/0", m_BVALID, B_src); end
        reset = 1'b0; s_BVALID = '0; m_BREADY = 1'b1;
        settle(); tick();
        checks++;
        if (m_BVALID !== 1'b0) begin errors++; $display("FAIL rmid_nore valid=%b exp=0", m_BVALID); end
        s_BVALID = 5'b10000; m_BREADY = 1'b0;
        settle();
        checks++;
        if (s_BREADY !== 5'b10000) begin errors++; $display("FAIL rmid_s4 got=%b exp=10000", s_BREADY); end
        tick();
        s_BVALID = '0; m_BREADY = 1'b1; settle(); tick();
    endtask

`ifdef BCHAN_ERR_CNT_EN
    task automatic test_err_cnt();
        logic [1:0] seq[6] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b00};
        do_reset();
        m_BREADY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            s_BVALID = 5'b00001; s_BRESP = '0; s_BRESP[1:0] = seq[c];
            settle(); tick();
        end
        s_BVALID = '0; settle(); tick();
        checks++;
        if (err_cnt !== 16'd4) begin errors++; $display("FAIL err_cnt got=%0d exp=4", err_cnt); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 39) == 0);
            s_BVALID = N'($urandom);
            m_BREADY = ($urandom_range(0, 3) != 0);
            rand_payload();
            settle();
            checks++;
            if (s_BREADY !== e_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, s_BREADY, e_ready); end
            tick();
            checks++;
            if (m_BVALID !== md_full || m_BID !== e_bid || m_BRESP !== e_resp ||
                m_BUSER !== e_user || int'(B_src) != e_src) begin
                errors++;
                $display("FAIL rand_out c=%0d v=%b/%b bid=%0d/%0d resp=%0d/%0d user=%0d/%0d src=%0d/%0d",
                         c, m_BVALID, md_full, m_BID, e_bid, m_BRESP, e_resp, m_BUSER, e_user, B_src, e_src);
            end
`ifdef BCHAN_ERR_CNT_EN
            checks++;
            if (int'(err_cnt) != e_err) begin errors++; $display("FAIL rand_err c=%0d got=%0d exp=%0d", c, err_cnt, e_err); end
`endif
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; s_BVALID = '0; m_BREADY = 1'b0; s_BID = '0; s_BRESP = '0; s_BUSER = '0;
        md_full = 0; md_ptr = 0; e_bid = '0; e_resp = '0; e_user = '0; e_src = 0; e_err = 0; e_ready = '0;
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_mid();
`ifdef BCHAN_ERR_CNT_EN
        test_err_cnt();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
